// File: rtl/vec_mem_sequencer.sv
// Vector load/store sequencer: splits one vector memory op into VLEN scalar word accesses.
// Optional per-op address stride is enabled by defining VEC_STRIDE_EN (default: unit stride).
//
// state | meaning
// IDLE  | waiting for start; accepting it latches the operation
// REQ   | issuing lane idx on the memory port until mem_ready
// DONE  | one-cycle completion pulse; start is ignored here
module vec_mem_sequencer #(
  parameter int VLEN   = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   is_store,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [VLEN*DATA_W-1:0] store_vec,
`ifdef VEC_STRIDE_EN
  input  logic [ADDR_W-1:0]      stride,
`endif
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic                   mem_ready,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic [VLEN*DATA_W-1:0] load_vec,
  output logic                   done,
  output logic                   busy
);

  localparam int IDX_W = $clog2(VLEN);

  typedef enum logic [1:0] {IDLE, REQ, DONE} stateE;

  stateE                   state, stateNext;
  logic [IDX_W-1:0]        idx;
  logic                    isStoreQ;
  logic [ADDR_W-1:0]       baseQ;
  logic [VLEN*DATA_W-1:0]  storeVecQ;
  logic [VLEN*DATA_W-1:0]  loadVecQ;
  logic [ADDR_W-1:0]       laneStep;
  logic                    lastLane;
  logic                    capture;
  logic                    inReq;

`ifdef VEC_STRIDE_EN
  logic [ADDR_W-1:0]       strideQ;
  assign laneStep = strideQ;
`else
  assign laneStep = ADDR_W'(DATA_W / 8);
`endif

  assign lastLane = (idx == IDX_W'(VLEN - 1));
  assign inReq    = (state == REQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // busy must already be low while reset is held, even if start is high
  always_comb begin
    stateNext = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    done      = 1'b0;
    busy      = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !reset) begin
          busy      = 1'b1;
          capture   = 1'b1;
          stateNext = REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        mem_we  = isStoreQ;
        busy    = 1'b1;
        if (mem_ready && lastLane) stateNext = DONE;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      isStoreQ  <= 1'b0;
      baseQ     <= '0;
      storeVecQ <= '0;
      loadVecQ  <= '0;
`ifdef VEC_STRIDE_EN
      strideQ   <= '0;
`endif
    end else if (capture) begin
      idx       <= '0;
      isStoreQ  <= is_store;
      baseQ     <= base_addr;
      storeVecQ <= store_vec;
`ifdef VEC_STRIDE_EN
      strideQ   <= stride;
`endif
    end else if (inReq && mem_ready) begin
      if (!isStoreQ) loadVecQ[idx*DATA_W +: DATA_W] <= mem_rdata;
      if (!lastLane) idx <= idx + IDX_W'(1);
    end
  end

  // address arithmetic wraps modulo 2^ADDR_W by truncation
  assign mem_addr  = inReq ? (baseQ + ADDR_W'(idx) * laneStep) : '0;
  assign mem_wdata = inReq ? storeVecQ[idx*DATA_W +: DATA_W] : '0;
  assign load_vec  = loadVecQ;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Self-checking bench for vec_mem_sequencer: queue-based reference model plus directed literal checks.
// Build with VEC_STRIDE_EN defined to also exercise the stride port.
module tb_vec_mem_sequencer;
  localparam int VLEN = 4;

  logic         clk = 1'b0;
  logic         reset, start, is_store, mem_ready;
  logic [31:0]  base_addr, mem_rdata, mem_addr, mem_wdata, rdKey;
  logic [127:0] store_vec, load_vec;
  logic         mem_req, mem_we, done, busy;
`ifdef VEC_STRIDE_EN
  logic [31:0]  stride;
`endif

  int nChecks = 0;
  int nPass = 0;

  vec_mem_sequencer #(.VLEN(4), .DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .base_addr(base_addr), .store_vec(store_vec),
`ifdef VEC_STRIDE_EN
    .stride(stride),
`endif
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .load_vec(load_vec),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr ^ 32'hA5A5A5A5 ^ rdKey;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Reference model: pending lane addresses as a queue, one pop per accepted beat.
  logic [31:0]  mQ[$];
  bit           mDone = 1'b0;
  bit           mStore = 1'b0;
  logic [127:0] mVec = '0;
  logic [127:0] mLoad = '0;

  function automatic logic [31:0] opStep();
`ifdef VEC_STRIDE_EN
    return stride;
`else
    return 32'd4;
`endif
  endfunction

  always @(negedge clk) begin
    bit expReq;
    int lane;
    logic [31:0] step;
    if (reset) begin
      chk("rst_outputs", 128'({mem_req, mem_we, done, busy, mem_addr, mem_wdata}), '0);
      chk("rst_load_vec", load_vec, '0);
      mQ.delete();
      mDone = 1'b0;
      mLoad = '0;
    end else begin
      expReq = (mQ.size() != 0);
      chk("busy", 128'(busy), 128'(expReq || (!mDone && start)));
      chk("done", 128'(done), 128'(mDone));
      chk("mem_req", 128'(mem_req), 128'(expReq));
      chk("load_vec", load_vec, mLoad);
      if (expReq) begin
        lane = VLEN - mQ.size();
        chk("mem_we", 128'(mem_we), 128'(mStore));
        chk("mem_addr", 128'(mem_addr), 128'(mQ[0]));
        if (mStore) chk("mem_wdata", 128'(mem_wdata), 128'(mVec[lane*32 +: 32]));
      end
      if (mDone) mDone = 1'b0;
      else if (expReq) begin
        if (mem_ready) begin
          lane = VLEN - mQ.size();
          if (!mStore) mLoad[lane*32 +: 32] = mQ[0] ^ 32'hA5A5A5A5 ^ rdKey;
          void'(mQ.pop_front());
          if (mQ.size() == 0) mDone = 1'b1;
        end
      end else if (start) begin
        mStore = is_store;
        mVec   = store_vec;
        step   = opStep();
        for (int i = 0; i < VLEN; i++) mQ.push_back(base_addr + 32'(i) * step);
      end
    end
  end

  logic [31:0] accAddr[$];
  logic [31:0] accData[$];

  function automatic logic [127:0] pack4(input logic [31:0] q[$]);
    logic [127:0] r = '0;
    for (int i = 0; i < 4 && i < q.size(); i++) r[i*32 +: 32] = q[i];
    return r;
  endfunction

  // mode 0: ready always; 1: random ready; 2: ready low for three cycles on lane 2
  task automatic runOp(input bit st, input logic [31:0] base, input logic [127:0] vec,
                       input logic [31:0] strd, input logic [31:0] key, input int mode,
                       output int doneAt, output int busyCnt);
    accAddr.delete();
    accData.delete();
    @(posedge clk); #1;
    start = 1'b1; is_store = st; base_addr = base; store_vec = vec; rdKey = key;
`ifdef VEC_STRIDE_EN
    stride = strd;
`else
    if (strd != 32'd4) $display("note: stride %h ignored in unit-stride build", strd);
`endif
    doneAt = -1;
    busyCnt = 0;
    for (int n = 0; n < 100; n++) begin
      case (mode)
        0: mem_ready = 1'b1;
        1: mem_ready = ($urandom_range(3) != 0);
        default: mem_ready = !(n >= 3 && n <= 5);
      endcase
      @(negedge clk);
      if (busy) busyCnt++;
      if (mem_req && mem_ready) begin
        accAddr.push_back(mem_addr);
        accData.push_back(mem_wdata);
      end
      if (done) begin
        doneAt = n;
        break;
      end
      @(posedge clk); #1;
    end
    if (doneAt < 0) chk("op_timeout", 128'(0), 128'(1));
    @(posedge clk); #1;
    start = 1'b0; is_store = $urandom_range(1); base_addr = $urandom; mem_ready = $urandom_range(1);
  endtask

  task automatic gap(input int k);
    repeat (k) begin
      @(posedge clk); #1;
      start = 1'b0;
      mem_ready = $urandom_range(1);
    end
  endtask

  localparam logic [127:0] T1_LOAD = 128'hA5A5A4A9_A5A5A4AD_A5A5A4A1_A5A5A4A5;

  initial begin
    int d, b, done5;
    logic [31:0] rb, rs;
    reset = 1'b1; start = 1'b1; is_store = 1'b0; base_addr = '0; store_vec = '0;
    mem_ready = 1'b0; rdKey = '0;
`ifdef VEC_STRIDE_EN
    stride = 32'd4;
`endif
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; reset = 1'b0;

    // 1: unit-stride load, zero-wait memory
    runOp(1'b0, 32'h100, '0, 32'd4, 32'd0, 0, d, b);
    chk("t1_done_cycle", 128'(d), 128'(5));
    chk("t1_busy_cycles", 128'(b), 128'(5));
    chk("t1_addrs", pack4(accAddr), 128'h0000010C_00000108_00000104_00000100);
    chk("t1_load_vec", load_vec, T1_LOAD);

    // 2: store leaves load_vec untouched
    runOp(1'b1, 32'h20, 128'h00000004_00000003_00000002_00000001, 32'd4, 32'd0, 0, d, b);
    chk("t2_addrs", pack4(accAddr), 128'h0000002C_00000028_00000024_00000020);
    chk("t2_wdata", pack4(accData), 128'h00000004_00000003_00000002_00000001);
    chk("t2_load_vec", load_vec, T1_LOAD);
    chk("t2_done_cycle", 128'(d), 128'(5));

    // 3: three wait cycles on lane 2
    runOp(1'b0, 32'h100, '0, 32'd4, 32'd0, 2, d, b);
    chk("t3_done_cycle", 128'(d), 128'(8));
    chk("t3_busy_cycles", 128'(b), 128'(8));
    chk("t3_addrs", pack4(accAddr), 128'h0000010C_00000108_00000104_00000100);

    // 4: address wrap
    runOp(1'b0, 32'hFFFFFFF8, '0, 32'd4, 32'd0, 0, d, b);
    chk("t4_addrs", pack4(accAddr), 128'h00000004_00000000_FFFFFFFC_FFFFFFF8);

    // 5: reset during lane 1, start held through reset
    @(posedge clk); #1;
    start = 1'b1; is_store = 1'b0; base_addr = 32'h200; mem_ready = 1'b1; rdKey = 32'd0;
`ifdef VEC_STRIDE_EN
    stride = 32'd4;
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_lane1_addr", 128'(mem_addr), 128'(32'h204));
    reset = 1'b1;
    #1;
    chk("t5_async_outs", 128'({mem_req, mem_we, done, busy, mem_addr, mem_wdata}), '0);
    chk("t5_async_load_vec", load_vec, '0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    accAddr.delete();
    done5 = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (mem_req && mem_ready) accAddr.push_back(mem_addr);
      if (done) begin
        done5 = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("t5_restart_done", 128'(done5), 128'(1));
    chk("t5_restart_addrs", pack4(accAddr), 128'h0000020C_00000208_00000204_00000200);
    @(posedge clk); #1; start = 1'b0;

`ifdef VEC_STRIDE_EN
    // 6: strided load, start held through DONE gives a single op
    runOp(1'b0, 32'h0, '0, 32'h40, 32'd0, 0, d, b);
    chk("t6_addrs", pack4(accAddr), 128'h000000C0_00000080_00000040_00000000);
    chk("t6_done_cycle", 128'(d), 128'(5));
    @(negedge clk);
    chk("t6_single_op", 128'({mem_req, busy}), '0);
    runOp(1'b0, 32'h300, '0, 32'h0, 32'd0, 0, d, b);
    chk("t6_zero_stride", pack4(accAddr), 128'h00000300_00000300_00000300_00000300);
`endif

    for (int k = 0; k < 60; k++) begin
      rb = ($urandom_range(3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(15))) : $urandom;
      case ($urandom_range(3))
        0: rs = 32'd0;
        1: rs = 32'd4;
        2: rs = 32'h40;
        default: rs = $urandom;
      endcase
`ifndef VEC_STRIDE_EN
      rs = 32'd4;
`endif
      runOp(1'($urandom_range(1)), rb, {$urandom, $urandom, $urandom, $urandom},
            rs, $urandom, 1, d, b);
      gap($urandom_range(3));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", nPass, nChecks);
    $fatal(1);
  end

endmodule
